// File: rtl/zle_stream_arb.sv
// zle_stream_arb: segment-granular round-robin arbiter that shares one ZLE
// encoder among NREQ token streams. A granted stream owns the encoder until
// its end-of-segment token transfers. The arbiter then flushes the encoder
// and waits for it to drain, so zero runs from different streams never merge.
module zle_stream_arb #(
  parameter int unsigned NREQ = 4,
  parameter int unsigned W    = 8,
  parameter int unsigned TMO  = 255
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NREQ-1:0]   req_v,
  output logic [NREQ-1:0]   req_b,
  input  logic [NREQ*W-1:0] req_d,
  input  logic [NREQ-1:0]   req_eos,
  input  logic [NREQ-1:0]   req_en,
  output logic              enc_v,
  input  logic              enc_b,
  output logic [W-1:0]      enc_d,
  output logic              enc_flush,
  input  logic              enc_idle,
  output logic [2:0]        grant_id,
  output logic [1:0]        stateo,
  output logic              err
);

  localparam int unsigned GW = 3;
  localparam int unsigned CW = 16;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_GRANT = 2'd1,
    S_FLUSH = 2'd2,
    S_WAIT  = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic [GW-1:0]   ptr_q, ptr_d;
  logic [GW-1:0]   grant_q, grant_d;
  logic            err_q, err_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [NREQ-1:0] elig;
  logic            found;
  logic [GW-1:0]   pick;
  logic            own_v;
  logic            own_eos;
  logic [W-1:0]    own_d;
  logic [GW-1:0]   nxt_ptr;
  logic [CW-1:0]   cnt_inc;
  logic            tmo_hit;

  // Rotating priority search: first eligible stream at or after ptr.
  always_comb begin
    elig  = req_v & req_en;
    found = 1'b0;
    pick  = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      for (int unsigned k = 0; k < NREQ; k++) begin
        if (!found && elig[k] && (((32'(ptr_q) + i) % NREQ) == k)) begin
          found = 1'b1;
          pick  = GW'(k);
        end
      end
    end
  end

  // Owner-side mux of valid, eos and data for the current grant.
  always_comb begin
    own_v   = 1'b0;
    own_eos = 1'b0;
    own_d   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      if (grant_q == GW'(k)) begin
        own_v   = req_v[k];
        own_eos = req_eos[k];
        own_d   = req_d[k*W +: W];
      end
    end
  end

  // Post-segment pointer (owner drops to lowest priority) and timeout compare.
  always_comb begin
    nxt_ptr = (grant_q == GW'(NREQ - 1)) ? '0 : grant_q + GW'(1);
    cnt_inc = cnt_q + CW'(1);
    tmo_hit = (cnt_inc >= CW'(TMO));
  end

  // Next-state and output decode; the req->enc path is combinational in GRANT.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    grant_d   = grant_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    req_b     = '1;
    enc_v     = 1'b0;
    enc_d     = '0;
    enc_flush = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (found) begin
          grant_d = pick;
          state_d = S_GRANT;
        end
      end
      S_GRANT: begin
        enc_v = own_v;
        enc_d = own_d;
        for (int unsigned k = 0; k < NREQ; k++) begin
          if (grant_q == GW'(k)) begin
            req_b[k] = enc_b;
          end
        end
        if (own_v && !enc_b && own_eos) begin
          state_d = S_FLUSH;
        end
      end
      S_FLUSH: begin
        enc_flush = 1'b1;
        cnt_d     = '0;
        state_d   = S_WAIT;
      end
      S_WAIT: begin
        if (enc_idle) begin
          ptr_d   = nxt_ptr;
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_inc;
          if (tmo_hit) begin
            err_d   = 1'b1;
            ptr_d   = nxt_ptr;
            state_d = S_IDLE;
          end
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
    end
  end

  // Debug and status views of the registered state.
  always_comb begin
    grant_id = grant_q;
    stateo   = state_q;
    err      = err_q;
  end

endmodule

// File: tb/tb_zle_stream_arb.sv
// Directed self-checking bench for zle_stream_arb (NREQ=4, W=8, TMO=4).
module tb_zle_stream_arb;

  localparam int unsigned NREQ = 4;
  localparam int unsigned W    = 8;
  localparam int unsigned TMO  = 4;

  logic              clock;
  logic              reset;
  logic [NREQ-1:0]   req_v;
  logic [NREQ-1:0]   req_b;
  logic [NREQ*W-1:0] req_d;
  logic [NREQ-1:0]   req_eos;
  logic [NREQ-1:0]   req_en;
  logic              enc_v;
  logic              enc_b;
  logic [W-1:0]      enc_d;
  logic              enc_flush;
  logic              enc_idle;
  logic [2:0]        grant_id;
  logic [1:0]        stateo;
  logic              err;

  int n_checks;
  int n_fail;

  zle_stream_arb #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
    .clock     (clock),
    .reset     (reset),
    .req_v     (req_v),
    .req_b     (req_b),
    .req_d     (req_d),
    .req_eos   (req_eos),
    .req_en    (req_en),
    .enc_v     (enc_v),
    .enc_b     (enc_b),
    .enc_d     (enc_d),
    .enc_flush (enc_flush),
    .enc_idle  (enc_idle),
    .grant_id  (grant_id),
    .stateo    (stateo),
    .err       (err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Single comparison point: counts and reports mismatches.
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic set_stream(input int k, input logic [W-1:0] d, input logic eos);
    req_d[k*W +: W] = d;
    req_eos[k]      = eos;
  endtask

  task automatic do_reset();
    reset    = 1'b0;
    req_v    = '0;
    req_eos  = '0;
    req_d    = '0;
    req_en   = '1;
    enc_b    = 1'b0;
    enc_idle = 1'b1;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic wait_state(input logic [1:0] exp, input string tag);
    int n = 0;
    while (stateo !== exp && n < 20) begin
      tick();
      n++;
    end
    check(tag, 32'(stateo), 32'(exp));
  endtask

  int tok [NREQ];

  initial begin
    n_checks = 0;
    n_fail   = 0;

    // Reset with every stream requesting.
    reset    = 1'b0;
    req_v    = 4'b1111;
    req_en   = 4'b1111;
    req_eos  = 4'b0001;
    req_d    = '0;
    req_d[7:0] = 8'hAA;
    enc_b    = 1'b0;
    enc_idle = 1'b1;
    tick(); tick(); tick();
    check("rst_req_b", 32'(req_b), 32'h0000000F);
    check("rst_enc_v", 32'(enc_v), 32'h0);
    check("rst_flush", 32'(enc_flush), 32'h0);
    check("rst_err",   32'(err), 32'h0);
    check("rst_state", 32'(stateo), 32'h0);
    reset = 1'b1;
    tick();
    check("rel_state", 32'(stateo), 32'h1);
    check("rel_grant", 32'(grant_id), 32'h0);
    check("rel_enc_d", 32'(enc_d), 32'hAA);
    check("rel_req_b", 32'(req_b), 32'hE);

    // Single segment on stream 2: 00, 00, 05(eos).
    do_reset();
    req_v[2] = 1'b1;
    set_stream(2, 8'h00, 1'b0);
    tick();
    check("s2_state", 32'(stateo), 32'h1);
    check("s2_grant", 32'(grant_id), 32'h2);
    check("s2_tok0",  32'(enc_d), 32'h00);
    check("s2_v0",    32'(enc_v), 32'h1);
    tick();
    check("s2_tok1",  32'(enc_d), 32'h00);
    check("s2_state1", 32'(stateo), 32'h1);
    tick();
    set_stream(2, 8'h05, 1'b1);
    #1;
    check("s2_tok2",  32'(enc_d), 32'h05);
    check("s2_noflush", 32'(enc_flush), 32'h0);
    tick();
    req_v = '0;
    check("s2_flush",  32'(enc_flush), 32'h1);
    check("s2_st_fl",  32'(stateo), 32'h2);
    tick();
    check("s2_flush_off", 32'(enc_flush), 32'h0);
    check("s2_st_wait", 32'(stateo), 32'h3);
    tick();
    check("s2_st_idle", 32'(stateo), 32'h0);
    check("s2_grant_hold", 32'(grant_id), 32'h2);

    // Round robin with 2-token segments on all streams.
    do_reset();
    for (int k = 0; k < NREQ; k++) begin
      tok[k] = 0;
      set_stream(k, 8'(16 * k), 1'b0);
    end
    req_v = 4'b1111;
    for (int s = 0; s < 5; s++) begin
      int o;
      o = s % NREQ;
      wait_state(2'd1, "rr_wait_grant");
      check("rr_grant", 32'(grant_id), 32'(o));
      for (int t = 0; t < 2; t++) begin
        #1;
        check("rr_enc_d", 32'(enc_d), 32'(16 * o + t));
        check("rr_req_b", 32'(req_b), 32'(~(4'b0001 << o) & 4'hF));
        tick();
        tok[o] = (tok[o] + 1) % 2;
        set_stream(o, 8'(16 * o + tok[o]), tok[o] == 1);
      end
    end

    // Back-pressure: stream 1, eos token stalled for 5 cycles.
    do_reset();
    req_v[1] = 1'b1;
    set_stream(1, 8'h11, 1'b0);
    tick();
    check("bp_grant", 32'(grant_id), 32'h1);
    check("bp_d0", 32'(enc_d), 32'h11);
    tick();
    set_stream(1, 8'h22, 1'b1);
    enc_b = 1'b1;
    for (int c = 0; c < 5; c++) begin
      #1;
      check("bp_req_b", 32'(req_b), 32'hF);
      check("bp_enc_v", 32'(enc_v), 32'h1);
      check("bp_enc_d", 32'(enc_d), 32'h22);
      tick();
      check("bp_state", 32'(stateo), 32'h1);
    end
    enc_b = 1'b0;
    #1;
    check("bp_release", 32'(req_b), 32'hD);
    tick();
    req_v = '0;
    check("bp_eos", 32'(stateo), 32'h2);

    // Mask 1010: only streams 1 and 3, alternating.
    do_reset();
    req_en  = 4'b1010;
    req_v   = 4'b1111;
    req_eos = 4'b1111;
    for (int s = 0; s < 4; s++) begin
      wait_state(2'd1, "mk_wait_grant");
      check("mk_grant", 32'(grant_id), (s % 2 == 0) ? 32'h1 : 32'h3);
      tick();
    end
    req_eos[1] = 1'b0;
    wait_state(2'd1, "mk_wait_g5");
    check("mk_grant5", 32'(grant_id), 32'h1);
    tick();
    req_en[1] = 1'b0;
    check("mk_mid_state", 32'(stateo), 32'h1);
    tick();
    check("mk_masked_hold", 32'(stateo), 32'h1);
    check("mk_masked_gid", 32'(grant_id), 32'h1);
    req_eos[1] = 1'b1;
    tick();
    check("mk_masked_eos", 32'(stateo), 32'h2);
    wait_state(2'd1, "mk_wait_g6");
    check("mk_grant6", 32'(grant_id), 32'h3);

    // Flush timeout with enc_idle stuck low.
    do_reset();
    enc_idle = 1'b0;
    req_v[0] = 1'b1;
    set_stream(0, 8'h01, 1'b1);
    tick();
    check("to_grant", 32'(grant_id), 32'h0);
    tick();
    req_v = '0;
    check("to_flush", 32'(stateo), 32'h2);
    tick();
    check("to_wait", 32'(stateo), 32'h3);
    tick(); tick(); tick();
    check("to_wait3", 32'(stateo), 32'h3);
    check("to_err_early", 32'(err), 32'h0);
    tick();
    check("to_idle", 32'(stateo), 32'h0);
    check("to_err", 32'(err), 32'h1);
    req_v    = 4'b1111;
    req_eos  = 4'b1111;
    enc_idle = 1'b1;
    tick();
    check("to_next_grant", 32'(grant_id), 32'h1);
    check("to_err_sticky", 32'(err), 32'h1);
    reset = 1'b0;
    tick();
    check("to_err_clear", 32'(err), 32'h0);
    reset = 1'b1;

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/zle_stream_arb.md
Name: zle_stream_arb

Overview:
- Shares one ZLE encoder datapath+FSM pair among NREQ independent input streams.
- Arbitration is segment-granular: a granted stream owns the encoder until it sends a token flagged end-of-segment.
- After each segment the arbiter pulses a flush to the encoder so the pending zero run is emitted. It then waits for the encoder to go idle before regranting, so zero runs from different streams never merge.
- Sits between the stream sources and the encoder input; the encoder output passes around it untouched.

Parameters:
- NREQ, 4, number of requesting streams, legal range 2..8.
- W, 8, token data width.
- TMO, 255, maximum cycles to wait for enc_idle after a flush. Range 1..65535; the counter is 16 bits.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- req_v  in  NREQ  per-stream valid.
- req_b  out  NREQ  per-stream back-pressure (1 = stall).
- req_d  in  NREQ*W  per-stream data; stream k occupies bits [k*W+W-1 : k*W].
- req_eos  in  NREQ  per-stream end-of-segment flag, qualified by req_v.
- req_en  in  NREQ  per-stream enable mask.
- enc_v  out  1  valid to encoder input.
- enc_b  in  1  encoder input back-pressure.
- enc_d  out  W  data to encoder.
- enc_flush  out  1  one-cycle flush pulse to encoder.
- enc_idle  in  1  encoder has no pending run and no output in flight.
- grant_id  out  3  index of the current or most recent owner.
- stateo  out  2  arbiter state, for debug and datapath tagging.
- err  out  1  sticky flush-timeout flag.

Behaviour:
- Handshake: a token transfers on a cycle where valid=1 and b=0. Data is qualified only when valid=1. Sources must hold data and eos stable while stalled.
- Reset (reset=0 at a clock edge): state=IDLE, ptr=0, grant_id=0, err=0, timeout count=0. Reset mid-segment abandons the segment without a flush.
- Output values that follow from the state:
  - IDLE, FLUSH, WAIT: req_b = all 1s, enc_v=0, enc_d=0.
- States (stateo encoding): IDLE=0, GRANT=1, FLUSH=2, WAIT=3.
- IDLE:
  - eligible[k] = req_v[k] & req_en[k].
  - If any stream is eligible, pick the first eligible index searching ptr, ptr+1, ... mod NREQ.
  - Register that index into grant_id and go to GRANT.
  - The grant decision is registered: the first token can transfer no earlier than the cycle after grant.
  - If nothing is eligible, stay in IDLE.
- GRANT (g = grant_id):
  - Outputs: enc_v=req_v[g], enc_d=req_d[g], req_b[g]=enc_b; every other req_b bit is 1.
  - Zero added latency: the path from req to enc is combinational.
  - A transfer with req_eos[g]=1 moves to FLUSH.
  - Deasserting req_en[g] mid-segment has no effect; ownership ends only at eos.
  - Zero-length segments do not exist: every segment is at least one token, the last one carrying eos.
- FLUSH: enc_flush=1 for exactly one cycle, then go to WAIT. Clear the timeout counter.
- WAIT:
  - enc_flush=0.
  - When enc_idle=1: set ptr=(g+1) mod NREQ and go to IDLE.
  - Otherwise increment the counter. When the counter reaches TMO, set err=1 (sticky until reset), advance ptr the same way, and go to IDLE.
  - enc_idle is ignored in every state other than WAIT.
- Fairness: after a segment completes, the owner has the lowest priority for the next grant. With all streams eligible, grants rotate 0,1,...,NREQ-1,0,...
- Simultaneous events: an eos transfer and new requests on the same cycle cause no grant; new requests are considered only in IDLE. Minimum gap between segments is 3 cycles (FLUSH, WAIT with enc_idle=1, IDLE).
- grant_id holds its value outside GRANT.
- Unused req_en bits above NREQ do not exist, because the vector width is NREQ.

Test Plan:
- Reset: hold reset=0 for 3 cycles with all req_v=1 -> req_b=4'b1111, enc_v=0, enc_flush=0, err=0, stateo=0. After release, stream 0 is granted (grant_id=0, stateo=1) one cycle later.
- Single segment: stream 2 only, sends tokens 0x00,0x00,0x05(eos) with enc_b=0 -> enc_d sequence 00,00,05 on consecutive cycles. enc_flush pulses for 1 cycle the cycle after eos. Tying enc_idle=1 returns the arbiter to IDLE 2 cycles later.
- Round robin: NREQ=4, all streams eligible, each sends 2-token segments -> grant order 0,1,2,3,0. No token from a non-owner reaches enc_d, and the req_b of non-owners stays 1 throughout.
- Back-pressure: stream 1 owner, enc_b=1 for 5 cycles mid-segment -> req_b[1]=1 and enc_v=req_v[1] during the stall. No token is lost or duplicated, and eos is honoured after the stall.
- Mask: req_en=4'b1010, all req_v=1 -> only streams 1 and 3 are granted, alternating. Clearing req_en[1] mid-segment of stream 1 still completes that segment through eos.
- Timeout: TMO=4, enc_idle held 0 after a flush -> err=1 after 4 WAIT cycles, arbiter returns to IDLE, next grant goes to g+1. err stays 1 until reset=0.
